// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture peripheral: register map, bit positions, FSM encoding.
package pwm_capture_pkg;

    localparam logic [11:0] ADDR_CTRL   = 12'h210;
    localparam logic [11:0] ADDR_STATUS = 12'h214;
    localparam logic [11:0] ADDR_HIGH   = 12'h218;
    localparam logic [11:0] ADDR_PERIOD = 12'h21C;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IE     = 1;

    localparam int unsigned ST_VALID    = 0;
    localparam int unsigned ST_OVERRUN  = 1;
    localparam int unsigned ST_STUCK    = 2;
    localparam int unsigned ST_LEVEL    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Synchronizes an asynchronous level into clk and flags its rising edge.
module pwm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period measurement peripheral with a small bus register file.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS_N,
    input  logic        RD_N,
    input  logic        WR_N,
    input  logic [11:0] Addr,
    input  logic [31:0] DataIn,
    input  logic        pwm_in,
    output logic [31:0] DataOut,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic               en_q, en_d, ie_q, ie_d;
    logic               valid_q, valid_d, overrun_q, overrun_d, stuck_q, stuck_d;
    logic [CNT_W-1:0]   per_q, per_d, hi_q, hi_d;
    logic [CNT_W-1:0]   high_q, period_q;
    logic               s, rise, capture, sat;
    logic               wr, rd, wr_ctrl, wr_status;
    logic               unused_data;

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pwm_in),
        .s     (s),
        .rise  (rise)
    );

    assign wr          = ~CS_N & ~WR_N;
    assign rd          = ~CS_N & ~RD_N;
    assign wr_ctrl     = wr && (Addr == ADDR_CTRL);
    assign wr_status   = wr && (Addr == ADDR_STATUS);
    assign unused_data = ^DataIn[31:3];

    // A disable written this cycle overrides any capture or saturation.
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hi_d      = hi_q;
        capture   = 1'b0;
        sat       = 1'b0;
        en_d      = wr_ctrl ? DataIn[CTRL_EN] : en_q;
        ie_d      = wr_ctrl ? DataIn[CTRL_IE] : ie_q;

        case (state_q)
            IDLE: begin
                per_d = '0;
                hi_d  = '0;
                if (en_q) state_d = ARM;
            end
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    per_d   = CNT_ONE;
                    hi_d    = CNT_ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                    per_d   = CNT_ONE;
                    hi_d    = CNT_ONE;
                end else if (per_q == CNT_MAX) begin
                    sat     = 1'b1;
                    state_d = ARM;
                    per_d   = '0;
                    hi_d    = '0;
                end else begin
                    per_d = per_q + CNT_ONE;
                    if (s) hi_d = hi_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en_d) begin
            state_d = IDLE;
            per_d   = '0;
            hi_d    = '0;
            capture = 1'b0;
            sat     = 1'b0;
        end

        // New events win over a same-cycle write-1-to-clear.
        valid_d   = valid_q;
        overrun_d = overrun_q;
        stuck_d   = stuck_q;
        if (wr_status && DataIn[ST_VALID])   valid_d   = 1'b0;
        if (wr_status && DataIn[ST_OVERRUN]) overrun_d = 1'b0;
        if (wr_status && DataIn[ST_STUCK])   stuck_d   = 1'b0;
        if (capture)            valid_d   = 1'b1;
        if (capture && valid_q) overrun_d = 1'b1;
        if (sat)                stuck_d   = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            stuck_q   <= 1'b0;
            per_q     <= '0;
            hi_q      <= '0;
            high_q    <= '0;
            period_q  <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            stuck_q   <= stuck_d;
            per_q     <= per_d;
            hi_q      <= hi_d;
            if (capture) begin
                high_q   <= hi_q;
                period_q <= per_q;
            end
        end
    end

    assign irq = valid_q & ie_q;

    always_comb begin
        DataOut = '0;
        if (rd) begin
            case (Addr)
                ADDR_CTRL:   DataOut = {30'b0, ie_q, en_q};
                ADDR_STATUS: DataOut = {28'b0, s, stuck_q, overrun_q, valid_q};
                ADDR_HIGH:   DataOut = 32'(high_q);
                ADDR_PERIOD: DataOut = 32'(period_q);
                default:     DataOut = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized self-checking bench for pwm_capture driven by an in-bench PWM source.
module tb_pwm_capture;

    localparam logic [11:0] A_CTRL   = 12'h210;
    localparam logic [11:0] A_STATUS = 12'h214;
    localparam logic [11:0] A_HIGH   = 12'h218;
    localparam logic [11:0] A_PERIOD = 12'h21C;
    localparam logic [11:0] A_UNMAP  = 12'h220;

    logic        clk = 1'b0;
    logic        reset;
    logic        CS_N, RD_N, WR_N;
    logic [11:0] Addr;
    logic [31:0] DataIn;
    logic        pwm_in;
    logic [31:0] DataOut;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    // PWM source: either a duty-register generator (256-tick period) or free high/period lengths
    bit use_duty = 1'b1;
    int duty     = 0;
    int hi_len   = 1;
    int per_len  = 256;
    int tick     = 0;

    pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS_N    (CS_N),
        .RD_N    (RD_N),
        .WR_N    (WR_N),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .pwm_in  (pwm_in),
        .DataOut (DataOut),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            if (tick >= (use_duty ? 256 : per_len) - 1) tick = 0;
            else tick++;
            pwm_in = use_duty ? (duty >= tick) : (tick < hi_len);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: cycles high per period for a duty setting is the number of ticks with duty >= tick
    function automatic int model_high(input int d);
        int n = 0;
        for (int t = 0; t < 256; t++) if (d >= t) n++;
        return n;
    endfunction

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
        @(negedge clk);
        CS_N = 1'b1; WR_N = 1'b1; DataIn = '0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        CS_N = 1'b0; RD_N = 1'b0; Addr = a;
        #2 d = DataOut;
        CS_N = 1'b1; RD_N = 1'b1;
    endtask

    task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic check_bit(input string tag, input logic [11:0] a, input int b, input logic exp);
        logic [31:0] d;
        bus_read(a, d);
        check_eq(tag, {31'b0, d[b]}, {31'b0, exp});
    endtask

    // Clear all status, then wait (bounded) for a fresh capture so the next reads are race-free.
    task automatic sync_capture(input string tag);
        logic [31:0] d;
        int n = 0;
        bus_write(A_STATUS, 32'h7);
        do begin
            bus_read(A_STATUS, d);
            n++;
        end while (!d[0] && n < 70000);
        check_eq(tag, {31'b0, d[0]}, 32'h1);
    endtask

    task automatic set_duty(input int d);
        use_duty = 1'b1;
        duty = d;
    endtask

    initial begin
        logic [31:0] d;
        int n, p, h;
        reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; Addr = '0; DataIn = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_reg("rst_ctrl",   A_CTRL,   32'h0);
        check_reg("rst_status", A_STATUS, 32'h0);
        check_reg("rst_high",   A_HIGH,   32'h0);
        check_reg("rst_period", A_PERIOD, 32'h0);
        check_reg("rst_unmap",  A_UNMAP,  32'h0);
        check_eq("rst_irq", {31'b0, irq}, 32'h0);

        // Duty 0x40
        set_duty(8'h40);
        bus_write(A_CTRL, 32'h3);
        check_reg("ctrl_rb", A_CTRL, 32'h3);
        repeat (3 * 256) @(negedge clk);
        sync_capture("cap_40");
        check_reg("high_40",   A_HIGH,   32'(model_high(8'h40)));
        check_reg("period_40", A_PERIOD, 32'd256);
        check_eq("irq_set", {31'b0, irq}, 32'h1);
        bus_write(A_STATUS, 32'h1);
        check_bit("valid_w1c", A_STATUS, 0, 1'b0);
        check_eq("irq_clr", {31'b0, irq}, 32'h0);
        bus_write(A_HIGH, 32'hFFFF);
        check_reg("ro_high", A_HIGH, 32'(model_high(8'h40)));

        // Duty 0x00, then let a second capture land on an uncleared valid
        set_duty(0);
        repeat (2 * 256 + 20) @(negedge clk);
        sync_capture("cap_00");
        check_reg("high_00",   A_HIGH,   32'(model_high(0)));
        check_reg("period_00", A_PERIOD, 32'd256);
        repeat (300) @(negedge clk);
        check_bit("overrun_set", A_STATUS, 1, 1'b1);
        bus_write(A_STATUS, 32'h2);
        check_bit("overrun_w1c", A_STATUS, 1, 1'b0);

        // Random high/period lengths
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(300, 8));
            h = int'($urandom_range(p - 1, 1));
            use_duty = 1'b0;
            per_len = p;
            hi_len = h;
            repeat (2 * p + 20) @(negedge clk);
            sync_capture("cap_rand");
            check_reg("high_rand",   A_HIGH,   32'(h));
            check_reg("period_rand", A_PERIOD, 32'(p));
        end

        // Stuck high: switch to 100% duty while the waveform is in its high phase
        set_duty(8'h40);
        repeat (2 * 256 + 20) @(negedge clk);
        sync_capture("cap_pre_stuck");
        set_duty(8'hFF);
        bus_write(A_STATUS, 32'h7);
        n = 0;
        do begin
            bus_read(A_STATUS, d);
            n++;
        end while (!d[2] && n < 70000);
        check_eq("stuck_set", {31'b0, d[2]}, 32'h1);
        check_eq("stuck_level", {31'b0, d[3]}, 32'h1);
        check_eq("stuck_novalid", {31'b0, d[0]}, 32'h0);
        check_reg("stuck_high",   A_HIGH,   32'(model_high(8'h40)));
        check_reg("stuck_period", A_PERIOD, 32'd256);

        set_duty(8'h80);
        repeat (3 * 256) @(negedge clk);
        sync_capture("cap_80");
        check_reg("high_80",   A_HIGH,   32'(model_high(8'h80)));
        check_reg("period_80", A_PERIOD, 32'd256);

        // Disable mid-period, then re-enable: results retained, no early capture
        repeat (100) @(negedge clk);
        bus_write(A_CTRL, 32'h0);
        check_reg("dis_ctrl", A_CTRL, 32'h0);
        check_reg("dis_high", A_HIGH, 32'(model_high(8'h80)));
        check_reg("dis_period", A_PERIOD, 32'd256);
        bus_write(A_STATUS, 32'h7);
        bus_write(A_CTRL, 32'h3);
        repeat (200) @(negedge clk);
        check_bit("reen_novalid", A_STATUS, 0, 1'b0);
        sync_capture("cap_reen");
        check_reg("reen_high",   A_HIGH,   32'(model_high(8'h80)));
        check_reg("reen_period", A_PERIOD, 32'd256);
        check_eq("pre_rst_irq", {31'b0, irq}, 32'h1);

        // Asynchronous reset in the middle of a measurement
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_eq("async_rst_irq", {31'b0, irq}, 32'h0);
        check_reg("mid_rst_ctrl",   A_CTRL,   32'h0);
        check_reg("mid_rst_status", A_STATUS, 32'h0);
        check_reg("mid_rst_high",   A_HIGH,   32'h0);
        check_reg("mid_rst_period", A_PERIOD, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        set_duty(8'h40);
        bus_write(A_CTRL, 32'h3);
        repeat (3 * 256) @(negedge clk);
        sync_capture("cap_post_rst");
        check_reg("post_rst_high",   A_HIGH,   32'(model_high(8'h40)));
        check_reg("post_rst_period", A_PERIOD, 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
